// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 constants and the sequencer state type.
package dlfloat_pkg;

    localparam int DL_W     = 16;
    localparam int EXP_BIAS = 31;
    localparam int EXP_W    = 6;
    localparam int MAN_W    = 9;

    localparam logic [DL_W-1:0] DL_ONE = 16'h3E00;
    localparam logic [DL_W-1:0] DL_TWO = 16'h4000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/dlfloat_seq_cnt.sv
// Loadable down-counter that saturates at zero and flags when it holds one.
module dlfloat_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q;

    // Load wins over decrement; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/dlfloat_mac_seq.sv
// Job sequencer feeding (a, b) pairs to the DLFloat16 MAC and returning its result.
module dlfloat_mac_seq
    import dlfloat_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 3,
    parameter int DW      = DL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mac_clr,
    output logic [DW-1:0]    mac_a,
    output logic [DW-1:0]    mac_b,
    output logic             mac_en,
    input  logic [DW-1:0]    mac_res,
    output logic [DW-1:0]    res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    localparam int DRAIN_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

    seq_state_t state_q, state_d;

    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] mac_a_q, mac_a_d;
    logic [DW-1:0] mac_b_q, mac_b_d;
    logic          mac_en_q, mac_en_d;
    logic          mac_clr_q, mac_clr_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d;
    logic          busy_q, busy_d;

    logic rem_load, rem_dec, rem_last;
    logic drn_load, drn_dec, drn_last;

    // Remaining operand pairs of the current job.
    dlfloat_seq_cnt #(.W(LEN_W)) u_rem_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rem_load),
        .load_val_i (len),
        .dec_i      (rem_dec),
        .last_o     (rem_last)
    );

    // Cycles left before the last pair's contribution shows on mac_res.
    dlfloat_seq_cnt #(.W(DRAIN_W)) u_drain_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (drn_load),
        .load_val_i (DRAIN_W'(MAC_LAT)),
        .dec_i      (drn_dec),
        .last_o     (drn_last)
    );

    // Next-state and next-output decode; issue strobes are prepared one cycle ahead so they are registered.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        mac_en_d    = 1'b0;
        mac_clr_d   = 1'b0;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        rem_load    = 1'b0;
        rem_dec     = 1'b0;
        drn_load    = 1'b0;
        drn_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        rem_load  = 1'b1;
                        mac_clr_d = 1'b1;
                        state_d   = ST_LOAD_A;
                    end else begin
                        res_data_d  = '0;
                        res_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_LOAD_A: begin
                if (in_valid) begin
                    a_d     = in_data;
                    state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (in_valid) begin
                    mac_a_d  = a_q;
                    mac_b_d  = in_data;
                    mac_en_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rem_dec = 1'b1;
                if (rem_last) begin
                    drn_load = 1'b1;
                    state_d  = ST_DRAIN;
                end else begin
                    state_d  = ST_LOAD_A;
                end
            end
            ST_DRAIN: begin
                drn_dec = 1'b1;
                if (drn_last) begin
                    res_data_d  = mac_res;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset abandons any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign mac_clr   = mac_clr_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_en    = mac_en_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// Self-checking bench for dlfloat_mac_seq with a real-valued MAC stand-in.
module tb_dlfloat_mac_seq;
    import dlfloat_pkg::*;

    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 3;
    localparam int DW      = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic             mac_clr;
    logic [DW-1:0]    mac_a;
    logic [DW-1:0]    mac_b;
    logic             mac_en;
    logic [DW-1:0]    macRes = '0;
    logic [DW-1:0]    res_data;
    logic             res_valid;
    logic             res_ready;
    logic             busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int enCount = 0;
    int clrCount = 0;
    int rvCount = 0;
    int enCyc = 0;
    int clrCyc = 0;
    int rvCyc = 0;
    logic prevRv = 1'b0;
    logic [DW-1:0] enA [1024];
    logic [DW-1:0] enB [1024];

    logic [DW-1:0] jobA [256];
    logic [DW-1:0] jobB [256];

    dlfloat_mac_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mac_clr   (mac_clr),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_en    (mac_en),
        .mac_res   (macRes),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic real dl2real(input logic [15:0] w);
        real v;
        int e;
        if (w[14:0] == 15'd0) return 0.0;
        e = int'(w[14:9]) - EXP_BIAS;
        v = 1.0 + real'(w[8:0]) / 512.0;
        if (e > 0) for (int i = 0; i < e; i++) v = v * 2.0;
        else for (int i = 0; i < -e; i++) v = v / 2.0;
        return w[15] ? -v : v;
    endfunction

    function automatic logic [15:0] real2dl(input real r);
        logic s;
        int e;
        int man;
        real m;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = EXP_BIAS;
        for (int i = 0; i < 40 && m >= 2.0; i++) begin m = m / 2.0; e++; end
        for (int i = 0; i < 40 && m < 1.0; i++) begin m = m * 2.0; e--; end
        man = $rtoi((m - 1.0) * 512.0);
        return {s, e[5:0], man[8:0]};
    endfunction

    function automatic logic [15:0] randOp();
        real pal [5] = '{0.0, 0.5, 1.0, 2.0, 3.0};
        return real2dl(pal[$urandom_range(0, 4)]);
    endfunction

    // Expected dot product of the first n staged pairs.
    function automatic logic [15:0] dotRef(input int n);
        real s = 0.0;
        for (int i = 0; i < n; i++) s = s + dl2real(jobA[i]) * dl2real(jobB[i]);
        return real2dl(s);
    endfunction

    // MAC stand-in: multiply stage, add stage, accumulator visible MAC_LAT cycles after mac_en.
    real p1 = 0.0, p2 = 0.0, acc = 0.0;
    logic v1 = 1'b0, v2 = 1'b0;
    always @(posedge clk or posedge rst) begin
        real nxt;
        if (rst) begin
            v1 <= 1'b0; v2 <= 1'b0; p1 <= 0.0; p2 <= 0.0; acc <= 0.0; macRes <= '0;
        end else begin
            nxt = mac_clr ? 0.0 : (v2 ? acc + p2 : acc);
            v1 <= mac_en;
            p1 <= dl2real(mac_a) * dl2real(mac_b);
            v2 <= v1;
            p2 <= p1;
            acc <= nxt;
            macRes <= real2dl(nxt);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Records issue strobes, clears and result rises with their cycle stamps.
    always @(negedge clk) begin
        if (mac_en === 1'b1) begin
            enA[enCount % 1024] = mac_a;
            enB[enCount % 1024] = mac_b;
            enCyc = cyc;
            enCount = enCount + 1;
        end
        if (mac_clr === 1'b1) begin
            clrCount = clrCount + 1;
            clrCyc = cyc;
        end
        if (res_valid === 1'b1 && prevRv !== 1'b1) begin
            rvCount = rvCount + 1;
            rvCyc = cyc;
        end
        prevRv = res_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startJob(input int n);
        start = 1'b1;
        len = LEN_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic sendWord(input logic [15:0] w, input int gap, output bit ok);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data = w;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = 16'($urandom);
    endtask

    task automatic feedJob(input int n, input int maxGap, output int timeouts);
        bit ok;
        timeouts = 0;
        for (int i = 0; i < n; i++) begin
            sendWord(jobA[i], $urandom_range(0, maxGap), ok);
            if (!ok) timeouts++;
            sendWord(jobB[i], $urandom_range(0, maxGap), ok);
            if (!ok) timeouts++;
        end
    endtask

    task automatic waitResult(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic acceptResult();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mac_clr, mac_en, res_valid, busy, in_ready} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl got %b want 00000", {mac_clr, mac_en, res_valid, busy, in_ready});
        end
        checks++;
        if ({mac_a, mac_b, res_data} !== 48'h0) begin
            errors++; $display("[TB] FAIL reset_data got %h want 0", {mac_a, mac_b, res_data});
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_after_reset busy=%b in_ready=%b want 0 0", busy, in_ready);
        end
        tick();
    endtask

    task automatic test_single_pair();
        int e0, c0, to;
        bit ok;
        e0 = enCount; c0 = clrCount;
        jobA[0] = DL_ONE; jobB[0] = DL_TWO;
        startJob(1);
        feedJob(1, 0, to);
        waitResult(30, ok);
        checks++;
        if (!ok || to != 0) begin errors++; $display("[TB] FAIL single_timeout ok=%0d timeouts=%0d want 1 0", ok, to); end
        checks++;
        if (clrCount - c0 != 1 || enCount - e0 != 1) begin
            errors++; $display("[TB] FAIL single_pulses clr=%0d en=%0d want 1 1", clrCount - c0, enCount - e0);
        end
        checks++;
        if (enA[e0 % 1024] !== 16'h3E00 || enB[e0 % 1024] !== 16'h4000) begin
            errors++; $display("[TB] FAIL single_operands got %h/%h want 3e00/4000", enA[e0 % 1024], enB[e0 % 1024]);
        end
        checks++;
        if (enCyc - clrCyc < 2) begin errors++; $display("[TB] FAIL clr_to_issue got %0d want >=2", enCyc - clrCyc); end
        checks++;
        if (rvCyc - enCyc != MAC_LAT + 1) begin
            errors++; $display("[TB] FAIL single_latency got %0d want %0d", rvCyc - enCyc, MAC_LAT + 1);
        end
        checks++;
        if (res_data !== 16'h4000) begin errors++; $display("[TB] FAIL single_result got %h want 4000", res_data); end
        acceptResult();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL single_release busy=%b res_valid=%b want 0 0", busy, res_valid);
        end
        tick();
    endtask

    task automatic test_three_pairs();
        int e0, to, bad;
        bit ok;
        e0 = enCount;
        for (int i = 0; i < 3; i++) begin jobA[i] = DL_ONE; jobB[i] = DL_ONE; end
        startJob(3);
        feedJob(3, 5, to);
        waitResult(40, ok);
        checks++;
        if (!ok || to != 0) begin errors++; $display("[TB] FAIL three_timeout ok=%0d timeouts=%0d want 1 0", ok, to); end
        checks++;
        if (enCount - e0 != 3) begin errors++; $display("[TB] FAIL three_en_count got %0d want 3", enCount - e0); end
        bad = 0;
        for (int i = 0; i < 3; i++)
            if (enA[(e0 + i) % 1024] !== jobA[i] || enB[(e0 + i) % 1024] !== jobB[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL three_operands bad=%0d want 0", bad); end
        checks++;
        if (res_data !== 16'h4100) begin errors++; $display("[TB] FAIL three_result got %h want 4100", res_data); end
        acceptResult();
        tick();
    endtask

    task automatic test_len_zero();
        int e0, c0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_pre_busy got %b want 0", busy); end
        tick();
        e0 = enCount; c0 = clrCount;
        startJob(0);
        @(negedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1 || res_data !== 16'h0000) begin
            errors++; $display("[TB] FAIL zero_result valid=%b busy=%b data=%h want 1 1 0000", res_valid, busy, res_data);
        end
        acceptResult();
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || enCount != e0 || clrCount != c0) begin
            errors++; $display("[TB] FAIL zero_after busy=%b valid=%b en=%0d clr=%0d want 0 0 0 0",
                                busy, res_valid, enCount - e0, clrCount - c0);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int c0, to, bad;
        bit ok;
        logic [15:0] exp;
        jobA[0] = randOp(); jobB[0] = randOp();
        exp = dotRef(1);
        startJob(1);
        feedJob(1, 0, to);
        waitResult(30, ok);
        checks++;
        if (!ok || to != 0 || res_data !== exp) begin
            errors++; $display("[TB] FAIL bp_result ok=%0d data=%h want 1 %h", ok, res_data, exp);
        end
        c0 = clrCount;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            len = 8'd2;
            in_valid = 1'b1;
            in_data = 16'($urandom);
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== exp) bad++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL bp_stable bad_cycles=%0d want 0", bad); end
        acceptResult();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_idle busy=%b valid=%b want 0 0", busy, res_valid);
        end
        repeat (4) tick();
        checks++;
        if (clrCount != c0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_start_ignored clr=%0d busy=%b want 0 0", clrCount - c0, busy);
        end
    endtask

    task automatic test_reset_mid_job();
        int e0, c0, r0, to;
        bit ok;
        jobA[0] = DL_TWO; jobB[0] = DL_TWO;
        startJob(4);
        sendWord(jobA[0], 0, ok);
        sendWord(jobB[0], 0, ok);
        sendWord(randOp(), 1, ok);
        r0 = rvCount;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mac_clr, mac_en, res_valid, busy, in_ready} !== 5'b0 || {mac_a, mac_b, res_data} !== 48'h0) begin
            errors++; $display("[TB] FAIL async_reset ctrl=%b data=%h want 0 0",
                                {mac_clr, mac_en, res_valid, busy, in_ready}, {mac_a, mac_b, res_data});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        e0 = enCount; c0 = clrCount;
        jobA[0] = randOp(); jobB[0] = randOp();
        startJob(1);
        feedJob(1, 1, to);
        waitResult(30, ok);
        checks++;
        if (!ok || to != 0 || res_data !== dotRef(1)) begin
            errors++; $display("[TB] FAIL post_reset_result ok=%0d data=%h want 1 %h", ok, res_data, dotRef(1));
        end
        checks++;
        if (clrCount - c0 != 1 || enCount - e0 != 1 || clrCyc >= enCyc || rvCount - r0 != 1) begin
            errors++; $display("[TB] FAIL post_reset_seq clr=%0d en=%0d results=%0d want 1 1 1",
                                clrCount - c0, enCount - e0, rvCount - r0);
        end
        acceptResult();
        tick();
    endtask

    task automatic test_max_len();
        int e0, r0, to, bad;
        bit ok;
        e0 = enCount; r0 = rvCount;
        for (int i = 0; i < 255; i++) begin jobA[i] = DL_ONE; jobB[i] = DL_ONE; end
        startJob(255);
        feedJob(255, 0, to);
        waitResult(40, ok);
        checks++;
        if (!ok || to != 0) begin errors++; $display("[TB] FAIL max_timeout ok=%0d timeouts=%0d want 1 0", ok, to); end
        bad = 0;
        for (int i = 0; i < 255; i++)
            if (enA[(e0 + i) % 1024] !== DL_ONE || enB[(e0 + i) % 1024] !== DL_ONE) bad++;
        checks++;
        if (enCount - e0 != 255 || bad != 0) begin
            errors++; $display("[TB] FAIL max_issues en=%0d bad=%0d want 255 0", enCount - e0, bad);
        end
        checks++;
        if (res_data !== 16'h4DFC) begin errors++; $display("[TB] FAIL max_result got %h want 4dfc", res_data); end
        acceptResult();
        repeat (6) tick();
        checks++;
        if (enCount - e0 != 255 || rvCount - r0 != 1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL max_no_wrap en=%0d results=%0d busy=%b want 255 1 0",
                                enCount - e0, rvCount - r0, busy);
        end
    endtask

    task automatic test_random_jobs();
        int e0, n, to, bad;
        bit ok;
        for (int j = 0; j < 4; j++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin jobA[i] = randOp(); jobB[i] = randOp(); end
            e0 = enCount;
            startJob(n);
            feedJob(n, 2, to);
            waitResult(40, ok);
            bad = 0;
            for (int i = 0; i < n; i++)
                if (enA[(e0 + i) % 1024] !== jobA[i] || enB[(e0 + i) % 1024] !== jobB[i]) bad++;
            checks++;
            if (!ok || to != 0 || enCount - e0 != n || bad != 0) begin
                errors++; $display("[TB] FAIL rand_issue job=%0d ok=%0d en=%0d bad=%0d want 1 %0d 0",
                                    j, ok, enCount - e0, bad, n);
            end
            checks++;
            if (res_data !== dotRef(n)) begin
                errors++; $display("[TB] FAIL rand_result job=%0d got %h want %h", j, res_data, dotRef(n));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            acceptResult();
            tick();
        end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        test_reset();
        test_single_pair();
        test_three_pairs();
        test_len_zero();
        test_backpressure();
        test_reset_mid_job();
        test_max_len();
        test_random_jobs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guards against a stuck handshake wedging the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/dlfloat_mac_seq.md
Name: dlfloat_mac_seq

Overview:
Sequencer for the DLFloat16 MAC datapath (multiplier → adder → accumulator register).
- Accepts a dot-product job of `len` operand pairs streamed one 16-bit word at a time over a valid/ready port.
- Clears the accumulator, issues each (a, b) pair to the MAC with a one-cycle enable, and waits out the pipeline latency.
- Presents the accumulated result on a valid/ready result port.
- Sits between the pad-level register wrapper and the MAC core, replacing ad-hoc two-phase operand capture.

Parameters:
- LEN_W, 8, width of job length / pair counter
- MAC_LAT, 3, cycles from a mac_en cycle until that pair's contribution is visible on mac_res
- DW, 16, DLFloat word width (1 sign, 6 exp bias 31, 9 mantissa)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  job request, sampled in IDLE only
- len  in  LEN_W  number of operand pairs, latched on accepted start
- in_data  in  DW  operand word; a then b, alternating
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts in_data this cycle
- mac_clr  out  1  one-cycle accumulator clear pulse
- mac_a  out  DW  operand A to MAC
- mac_b  out  DW  operand B to MAC
- mac_en  out  1  one-cycle issue strobe for mac_a/mac_b
- mac_res  in  DW  MAC accumulator output
- res_data  out  DW  job result
- res_valid  out  1  res_data valid
- res_ready  in  1  consumer accepts result
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous, active-high.
- Reset values: all outputs 0. State IDLE, counters 0, operand registers 0. Reset mid-job abandons the job with no result.
- All outputs are registered, except `in_ready`, which is decoded from state.
- States:
  - IDLE, LOAD_A, LOAD_B, ISSUE, DRAIN, DONE.
- IDLE:
  - `in_ready` = 0, `busy` = 0.
  - On `start` with `len` != 0: latch `len` into `rem`; `mac_clr` = 1 next cycle; go to LOAD_A.
  - On `start` with `len` == 0: `res_data` ← 0x0000; go to DONE.
- LOAD_A:
  - `in_ready` = 1.
  - On `in_valid`: `a_reg` ← `in_data`; go to LOAD_B.
- LOAD_B:
  - `in_ready` = 1.
  - On `in_valid`: `b_reg` ← `in_data`; go to ISSUE.
- ISSUE (one cycle):
  - `mac_a` = `a_reg`, `mac_b` = `b_reg`, `mac_en` = 1; `rem` ← `rem` − 1.
  - If `rem` was 1, load `drain_cnt` ← MAC_LAT and go to DRAIN; else go to LOAD_A.
  - `mac_a`/`mac_b` hold their value until the next ISSUE.
- DRAIN:
  - `drain_cnt` decrements each cycle.
  - When `drain_cnt` == 1: `res_data` ← `mac_res`; go to DONE.
- DONE:
  - `res_valid` = 1; `res_data` stable.
  - On `res_ready`: `res_valid` ← 0; go to IDLE.
  - `res_ready` arriving in the same cycle `res_valid` first rises counts as acceptance.
- Timing:
  - `mac_clr` and the first ISSUE are at least 2 cycles apart, since the clear completes before the first pair.
  - Pair throughput: at most 1 pair per 3 cycles.
  - Latency from the last `mac_en` to `res_valid` = MAC_LAT + 1 cycles.
- Boundaries:
  - `start` while `busy` is ignored and not queued.
  - `in_valid` gaps stall in LOAD_A/LOAD_B indefinitely.
  - `len` = 2^LEN_W − 1 must work; the `rem` counter never wraps.
  - Words offered while `in_ready` = 0 are not consumed.
  - The sequencer does no arithmetic on operands; zero/denormal handling belongs to the MAC.

Decomposition:
- Package `dlfloat_pkg`:
  - DL_W = 16.
  - DLFloat field constants: EXP_BIAS = 31, EXP_W = 6, MAN_W = 9.
  - `seq_state_t` enum for the six states.
  - DL_ONE = 16'h3E00 and DL_TWO = 16'h4000 for benches.
- One natural sub-module: `dlfloat_seq_cnt`, a loadable down-counter with a `last` flag. Instantiate it twice: pair counter (LEN_W bits) and drain counter.

Test Plan:
- Single pair:
  - Stimulus: `len` = 1, a = 0x3E00, b = 0x4000; bench MAC model with MAC_LAT = 3.
  - Response: `mac_clr` pulse, then `mac_en` once with `mac_a` = 0x3E00 and `mac_b` = 0x4000; `res_valid` exactly 4 cycles after `mac_en`; `res_data` = 0x4000.
- Three pairs with `in_valid` deasserted randomly 0–5 cycles:
  - Stimulus: pairs (0x3E00, 0x3E00) ×3.
  - Response: exactly 3 `mac_en` pulses, each a/b pair correct; `res_data` = 0x4100 (3.0).
- `len` = 0:
  - Response: `busy` for the DONE state only; `res_valid` 1 cycle after `start`; `res_data` = 0x0000; no `mac_clr` or `mac_en`.
- Result backpressure:
  - Stimulus: `res_ready` held low for 10 cycles.
  - Response: `res_valid` and `res_data` stable; `start` pulses are ignored, with no `mac_clr`; IDLE is entered on the cycle after `res_ready` = 1.
- Reset mid-job:
  - Stimulus: assert `rst` in LOAD_B of pair 2 of 4.
  - Response: all outputs 0 immediately (async). After release, a new `len` = 1 job completes normally with `mac_clr` first.
- Max length:
  - Stimulus: `len` = 255.
  - Response: 255 `mac_en` pulses; `rem` reaches 0 without wrap; single `res_valid`.
